// File: rtl/fir_frame_scheduler_pkg.sv
// Shared definitions for the mic-array FIR frame scheduler: FSM state
// encoding, default geometry and a power-of-2 helper for the tap count.
package fir_frame_scheduler_pkg;

   localparam int DEF_CHANNELS   = 8;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_FIR_TAP    = 128;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_START   = 3'd2,
      S_WAIT    = 3'd3,
      S_DONE    = 3'd4
   } sched_state_e;

   // The history pointer wraps naturally, so the tap count must be 2^n.
   function automatic bit is_pow2(input int unsigned n);
      return (n != 0) && ((n & (n - 1)) == 0);
   endfunction

   localparam bit DEF_FIR_TAP_IS_POW2 = is_pow2(DEF_FIR_TAP);

endpackage

// File: rtl/fir_frame_scheduler_if.sv
// Sample stream, history-memory write port and FIR pipe handshake.
// master = scheduler side, slave = decimator / memory / pipe side.
interface fir_frame_scheduler_if
   import fir_frame_scheduler_pkg::*;
#(
   parameter int CHANNELS_WIDTH  = 3,
   parameter int TAP_COUNT_WIDTH = $clog2(DEF_FIR_TAP),
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH
);
   logic                                      in_valid;
   logic [CHANNELS_WIDTH-1:0]                 in_channel;
   logic [DATA_WIDTH-1:0]                     in_data;
   logic                                      in_ready;
   logic                                      mem_we;
   logic [CHANNELS_WIDTH+TAP_COUNT_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0]                     mem_wdata;
   logic                                      start_pipe;
   logic [TAP_COUNT_WIDTH-1:0]                tap_base;
   logic                                      pipe_write_data;
   logic                                      frame_done;

   modport master (
      input  in_valid, in_channel, in_data, pipe_write_data,
      output in_ready, mem_we, mem_waddr, mem_wdata, start_pipe, tap_base, frame_done
   );

   modport slave (
      output in_valid, in_channel, in_data, pipe_write_data,
      input  in_ready, mem_we, mem_waddr, mem_wdata, start_pipe, tap_base, frame_done
   );

endinterface

// File: rtl/fir_frame_scheduler_sat_counter.sv
// Saturating event counter: counts up on inc_i and sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign count_d = count_q + WIDTH'(1);

   // Increment unless already saturated; async clear wins.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fir_frame_scheduler.sv
// Frame scheduler for the mic-array FIR pipe: collects one in-order sample
// per channel into the circular history memory, kicks the pipe once per
// complete frame and waits for all channel results before the next frame.
module fir_frame_scheduler
   import fir_frame_scheduler_pkg::*;
#(
   parameter int CHANNELS        = DEF_CHANNELS,
   parameter int CHANNELS_WIDTH  = 3,
   parameter int FIR_TAP         = DEF_FIR_TAP,
   parameter int TAP_COUNT_WIDTH = $clog2(FIR_TAP),
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   fir_frame_scheduler_if.master bus,
   output logic                 overrun,
   output logic                 seq_error,
   output logic [15:0]          overrun_count
);

   if (!is_pow2(FIR_TAP) || !DEF_FIR_TAP_IS_POW2) begin : g_bad_fir_tap
      $error("fir_frame_scheduler: FIR_TAP must be a power of 2");
   end

   localparam logic [CHANNELS_WIDTH-1:0] LAST_CH = CHANNELS_WIDTH'(CHANNELS - 1);

   sched_state_e                              state_q;
   logic [CHANNELS_WIDTH-1:0]                 exp_ch_q;
   logic [CHANNELS_WIDTH-1:0]                 res_cnt_q;
   logic [TAP_COUNT_WIDTH-1:0]                wr_ptr_q;
   logic [TAP_COUNT_WIDTH-1:0]                wr_ptr_d;
   logic [TAP_COUNT_WIDTH-1:0]                tap_base_q;
   logic                                      mem_we_q;
   logic [CHANNELS_WIDTH+TAP_COUNT_WIDTH-1:0] mem_waddr_q;
   logic [DATA_WIDTH-1:0]                     mem_wdata_q;
   logic                                      start_q;
   logic                                      done_q;
   logic                                      overrun_q;
   logic                                      seq_err_q;

   logic ch_match;
   logic ch_restart;
   logic not_ready_hit;

   assign ch_match      = (bus.in_channel == exp_ch_q);
   // A channel-0 tag out of sequence resynchronises on a fresh frame.
   assign ch_restart    = (bus.in_channel == '0);
   assign not_ready_hit = bus.in_valid && (state_q != S_COLLECT);
   // Natural binary wrap of the circular history pointer.
   assign wr_ptr_d      = wr_ptr_q + TAP_COUNT_WIDTH'(1);

   // Scheduler FSM with registered strobes, memory write port and pointers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         exp_ch_q    <= '0;
         res_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         tap_base_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= '0;
         mem_wdata_q <= '0;
         start_q     <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         mem_we_q  <= 1'b0;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         seq_err_q <= 1'b0;
         overrun_q <= not_ready_hit;

         case (state_q)
            S_IDLE: begin
               if (enable) begin
                  state_q  <= S_COLLECT;
                  exp_ch_q <= '0;
               end
            end

            S_COLLECT: begin
               if (!enable) begin
                  // Partial frame is dropped; wr_ptr stays so the slot is reused.
                  state_q  <= S_IDLE;
                  exp_ch_q <= '0;
               end else if (bus.in_valid) begin
                  if (ch_match || ch_restart) begin
                     mem_we_q    <= 1'b1;
                     mem_waddr_q <= {bus.in_channel, wr_ptr_q};
                     mem_wdata_q <= bus.in_data;
                  end
                  if (ch_match) begin
                     if (exp_ch_q == LAST_CH) begin
                        exp_ch_q <= '0;
                        state_q  <= S_START;
                     end else begin
                        exp_ch_q <= exp_ch_q + CHANNELS_WIDTH'(1);
                     end
                  end else begin
                     seq_err_q <= 1'b1;
                     exp_ch_q  <= ch_restart ? CHANNELS_WIDTH'(1) : '0;
                  end
               end
            end

            S_START: begin
               // The newest slot is the one just written; advance for the next frame.
               start_q    <= 1'b1;
               tap_base_q <= wr_ptr_q;
               wr_ptr_q   <= wr_ptr_d;
               res_cnt_q  <= '0;
               state_q    <= S_WAIT;
            end

            S_WAIT: begin
               if (bus.pipe_write_data) begin
                  if (res_cnt_q == LAST_CH) begin
                     res_cnt_q <= '0;
                     done_q    <= 1'b1;
                     state_q   <= S_DONE;
                  end else begin
                     res_cnt_q <= res_cnt_q + CHANNELS_WIDTH'(1);
                  end
               end
            end

            S_DONE: begin
               exp_ch_q  <= '0;
               res_cnt_q <= '0;
               state_q   <= enable ? S_COLLECT : S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   sat_counter #(
      .WIDTH (16)
   ) u_overrun_cnt (
      .clk     (clk),
      .clr_n   (resetn),
      .inc_i   (not_ready_hit),
      .count_o (overrun_count)
   );

   assign bus.in_ready   = (state_q == S_COLLECT);
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_waddr  = mem_waddr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.start_pipe = start_q;
   assign bus.tap_base   = tap_base_q;
   assign bus.frame_done = done_q;
   assign overrun        = overrun_q;
   assign seq_error      = seq_err_q;

endmodule
